// File: rtl/shift_unit_if.sv
// Operand/result handshake bundle for shift_unit: the issue side is the master and the unit is the slave.
interface shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROL/ROR unit, MAX_STEP bits per BUSY cycle; latency max(1, ceil(rem/MAX_STEP)).
// Holds the result in DONE until out_ready; accepts nothing outside IDLE (no pipelining).
module shift_unit #(
    parameter int WIDTH    = 32,
    parameter int MAX_STEP = 8,
    parameter int SHW      = $clog2(WIDTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    shift_unit_if.slave bus
);
    localparam int LW = $clog2(WIDTH);
    localparam logic [SHW-1:0] WIDTH_W = SHW'(WIDTH);
    localparam logic [SHW-1:0] STEP_W  = SHW'(MAX_STEP);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [SHW-1:0]   rem, rem_nx;
    logic [SHW-1:0]   step;
    logic [2:0]       op, op_nx;
    logic             err, err_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            rem   <= '0;
            op    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            rem   <= rem_nx;
            op    <= op_nx;
            err   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        work_nx  = work;
        rem_nx   = rem;
        op_nx    = op;
        err_nx   = err;
        step     = (rem > STEP_W) ? STEP_W : rem;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    work_nx  = bus.in_data;
                    op_nx    = bus.in_op;
                    err_nx   = 1'b0;
                    state_nx = BUSY;
                    case (bus.in_op)
                        OP_SLL, OP_SRL, OP_SRA:
                            rem_nx = (bus.in_amt >= WIDTH_W) ? WIDTH_W : bus.in_amt;
                        OP_ROL, OP_ROR:
                            rem_nx = {1'b0, bus.in_amt[LW-1:0]};
                        default: begin
                            rem_nx = '0;
                            err_nx = 1'b1;
                        end
                    endcase
                end
            end
            BUSY: begin
                // A shift by WIDTH yields zero, so rotates by step 0 degrade cleanly to identity.
                case (op)
                    OP_SLL:  work_nx = work << step;
                    OP_SRL:  work_nx = work >> step;
                    OP_SRA:  work_nx = $signed(work) >>> step;
                    OP_ROL:  work_nx = (work << step) | (work >> (WIDTH_W - step));
                    OP_ROR:  work_nx = (work >> step) | (work << (WIDTH_W - step));
                    default: work_nx = work;
                endcase
                rem_nx = rem - step;
                if (rem == step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = work;
    assign bus.out_err   = err;
endmodule

// File: tb/tb_shift_unit.sv
// Directed vector bench for shift_unit (WIDTH=32, MAX_STEP=8) plus backpressure and reset corner sequences.
module tb_shift_unit;
    localparam int WIDTH    = 32;
    localparam int MAX_STEP = 8;
    localparam int SHW      = $clog2(WIDTH) + 1;

    typedef struct {
        logic [31:0]    data;
        logic [SHW-1:0] amt;
        logic [2:0]     op;
        logic [31:0]    exp_data;
        logic           exp_err;
        int             exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_unit_if #(.WIDTH(WIDTH)) bus ();
    shift_unit #(.WIDTH(WIDTH), .MAX_STEP(MAX_STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] got_data;
    logic        got_err;
    int          got_lat;
    vec_t        vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Present one op, wait for out_valid, and leave the result held (out_ready stays 0).
    task automatic apply_op(input logic [31:0] d, input logic [SHW-1:0] a, input logic [2:0] o);
        int guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_op    = o;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h5A5A_5A5A;
        bus.in_amt   = '1;
        bus.in_op    = 3'b000;
        got_lat = 0;
        while (!bus.out_valid && got_lat < 20) begin
            @(posedge clk); #1;
            got_lat++;
        end
        got_data = bus.out_data;
        got_err  = bus.out_err;
    endtask

    task automatic finish_op(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, "_in_ready_after_hs"}, 32'(bus.in_ready), 32'd1);
        check({name, "_out_valid_after_hs"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0001, 6'd31, 3'b000, 32'h8000_0000, 1'b0, 4};
        vecs[1]  = '{32'h8000_00F0, 6'd4,  3'b010, 32'hF800_000F, 1'b0, 1};
        vecs[2]  = '{32'h8000_00F0, 6'd40, 3'b010, 32'hFFFF_FFFF, 1'b0, 4};
        vecs[3]  = '{32'h8000_00F0, 6'd40, 3'b001, 32'h0000_0000, 1'b0, 4};
        vecs[4]  = '{32'h1234_5678, 6'd8,  3'b100, 32'h7812_3456, 1'b0, 1};
        vecs[5]  = '{32'h8000_0001, 6'd1,  3'b011, 32'h0000_0003, 1'b0, 1};
        vecs[6]  = '{32'h1234_5678, 6'd32, 3'b011, 32'h1234_5678, 1'b0, 1};
        vecs[7]  = '{32'hDEAD_BEEF, 6'd5,  3'b111, 32'hDEAD_BEEF, 1'b1, 1};
        vecs[8]  = '{32'h1234_5678, 6'd63, 3'b100, 32'h2468_ACF0, 1'b0, 4};
        vecs[9]  = '{32'h0000_00A5, 6'd0,  3'b000, 32'h0000_00A5, 1'b0, 1};
        vecs[10] = '{32'h7FFF_FFFF, 6'd40, 3'b010, 32'h0000_0000, 1'b0, 4};
        vecs[11] = '{32'hF000_0000, 6'd9,  3'b001, 32'h0078_0000, 1'b0, 2};
        vecs[12] = '{32'h1234_5678, 6'd63, 3'b101, 32'h1234_5678, 1'b1, 1};
        vecs[13] = '{32'h0000_0003, 6'd17, 3'b000, 32'h0006_0000, 1'b0, 3};
        vecs[14] = '{32'h8000_0000, 6'd33, 3'b011, 32'h0000_0001, 1'b0, 1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", bus.out_data, 32'd0);
        check("reset_out_err", 32'(bus.out_err), 32'd0);

        for (int i = 0; i < 15; i++) begin
            apply_op(vecs[i].data, vecs[i].amt, vecs[i].op);
            check($sformatf("vec%0d_data", i), got_data, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), got_lat, vecs[i].exp_lat);
            finish_op($sformatf("vec%0d", i));
        end

        // Backpressure: result held for 3 cycles while stray in_valid pulses arrive.
        apply_op(32'h0000_00F0, 6'd4, 3'b001);
        check("bp_data", got_data, 32'h0000_000F);
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            bus.in_amt   = 6'd3;
            bus.in_op    = 3'b011;
            @(posedge clk); #1;
            check($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d_out_data", c), bus.out_data, 32'h0000_000F);
            check($sformatf("bp%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        finish_op("bp");
        apply_op(32'h0000_0001, 6'd4, 3'b000);
        check("bp_b2b_data", got_data, 32'h0000_0010);
        check("bp_b2b_latency", got_lat, 1);
        finish_op("bp_b2b");

        // Reset two edges after accepting a long SLL: the op must vanish.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0001;
        bus.in_amt   = 6'd31;
        bus.in_op    = 3'b000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy_out_data", bus.out_data, 32'd0);
        check("rst_busy_out_err", 32'(bus.out_err), 32'd0);
        check("rst_busy_in_ready", 32'(bus.in_ready), 32'd1);
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1;
                if (bus.out_valid) seen++;
            end
            check("rst_busy_no_result", seen, 0);
        end
        apply_op(32'h1234_5678, 6'd12, 3'b011);
        check("post_rst_data", got_data, 32'h4567_8123);
        check("post_rst_latency", got_lat, 2);
        finish_op("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
